// File: rtl/skyhop_pkg.sv
// Shared types and constants for the skyhop VGA game: stage encodings,
// per-stage overlay enables and default frame timing.
package skyhop_pkg;

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_OVER      = 2'd3
  } game_state_t;

  typedef struct packed {
    logic start_screen;
    logic countdown;
    logic game;
    logic game_over;
  } stage_en_t;

  localparam int FPS                  = 60;
  localparam int DEF_COUNTDOWN_FRAMES = 3 * FPS;
  localparam int DEF_OVER_FRAMES      = 4 * FPS;
  localparam int VGA_CNT_W            = 11;

  function automatic stage_en_t stage_enables(input game_state_t s);
    stage_en_t e;
    e.start_screen = (s == ST_START);
    e.countdown    = (s == ST_COUNTDOWN);
    e.game         = (s == ST_PLAY);
    e.game_over    = (s == ST_OVER);
    return e;
  endfunction

endpackage

// File: rtl/frame_sync.sv
// Turns the vertical-blank level into a single-cycle pulse at the start of
// each blanking interval; shared by every block that updates once per frame.
module frame_sync (
  input  logic clk,
  input  logic rst,
  input  logic vblnk_in,
  output logic frame_tick
);

  logic vblnk_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Starting "already in blank" suppresses a tick if vblnk is high at release.
      vblnk_d    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d    <= vblnk_in;
      frame_tick <= vblnk_in & ~vblnk_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-synchronous game stage sequencer: START -> COUNTDOWN -> PLAY -> OVER.
// Stage changes only at the end of a frame_tick cycle, so overlays never switch mid-frame.
module game_flow_ctrl
  import skyhop_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
  parameter int OVER_FRAMES      = DEF_OVER_FRAMES,
  parameter int CNT_W            = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       btn_start,
  input  logic       player_dead,
  output logic       frame_tick,
  output logic [1:0] state_out,
  output logic       start_screen_en,
  output logic       countdown_en,
  output logic       game_en,
  output logic       game_over_en,
  output logic       score_rst,
  output logic [1:0] countdown_val
);

  localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_FRAMES - 1);
  // Smallest counts with counter*3 >= N and counter*3 >= 2N: no divider needed.
  localparam logic [CNT_W-1:0] CD_TH1    = CNT_W'((COUNTDOWN_FRAMES + 2) / 3);
  localparam logic [CNT_W-1:0] CD_TH2    = CNT_W'((2 * COUNTDOWN_FRAMES + 2) / 3);

  game_state_t      state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  stage_en_t        en, en_nxt;
  logic [1:0]       cd_val_nxt;
  logic             score_rst_nxt;

  logic btn_d, btn_rise, btn_pend, dead_pend;
  logic btn_hit, dead_hit;

  frame_sync u_frame_sync (
    .clk        (clk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .frame_tick (frame_tick)
  );

  // Events are latched across the frame and consumed on the tick; an event
  // landing in the tick cycle itself is folded in combinationally.
  assign btn_rise = btn_start & ~btn_d;
  assign btn_hit  = btn_pend | btn_rise;
  assign dead_hit = dead_pend | player_dead;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_d     <= 1'b1;
      btn_pend  <= 1'b0;
      dead_pend <= 1'b0;
    end else begin
      btn_d <= btn_start;
      if (frame_tick) begin
        btn_pend  <= 1'b0;
        dead_pend <= 1'b0;
      end else begin
        btn_pend  <= btn_pend | btn_rise;
        dead_pend <= dead_pend | player_dead;
      end
    end
  end

  // State register; enables and countdown value are registered from next-state
  // so they move on the same edge as state_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_START;
      frame_cnt     <= '0;
      en            <= stage_enables(ST_START);
      countdown_val <= 2'd3;
      score_rst     <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_cnt     <= cnt_nxt;
      en            <= en_nxt;
      countdown_val <= cd_val_nxt;
      score_rst     <= score_rst_nxt;
    end
  end

  // NOTE: every variable gets a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = frame_cnt;
    score_rst_nxt = 1'b0;
    if (frame_tick) begin
      unique case (state)
        ST_START: begin
          if (btn_hit) begin
            state_nxt     = ST_COUNTDOWN;
            cnt_nxt       = '0;
            score_rst_nxt = 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_cnt == CD_LAST) begin
            state_nxt = ST_PLAY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (dead_hit) begin
            state_nxt = ST_OVER;
            cnt_nxt   = '0;
          end
        end
        ST_OVER: begin
          if (frame_cnt == OVER_LAST) begin
            state_nxt = ST_START;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    en_nxt     = stage_enables(state_nxt);
    cd_val_nxt = 2'd3;
    if (state_nxt == ST_COUNTDOWN) begin
      if (cnt_nxt >= CD_TH2) begin
        cd_val_nxt = 2'd1;
      end else if (cnt_nxt >= CD_TH1) begin
        cd_val_nxt = 2'd2;
      end
    end
  end

  assign state_out       = state;
  assign start_screen_en = en.start_screen;
  assign countdown_en    = en.countdown;
  assign game_en         = en.game;
  assign game_over_en    = en.game_over;

  a_stage_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot({start_screen_en, countdown_en, game_en, game_over_en}));

  a_game_only_in_play: assert property (@(posedge clk) disable iff (rst)
    game_en == (state == ST_PLAY));

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scenarios plus randomized frames against a frame-level reference
// model of the game stage sequencer.
module tb_game_flow_ctrl;

  localparam int CD_FRAMES = 3;
  localparam int OV_FRAMES = 2;

  logic       clk = 1'b0;
  logic       rst, vblnk_in, btn_start, player_dead;
  logic       frame_tick, start_screen_en, countdown_en, game_en, game_over_en, score_rst;
  logic [1:0] state_out, countdown_val;
  logic [3:0] en_obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stage index, frames completed in stage, and events seen this frame.
  int m_stage  = 0;
  int m_frames = 0;
  bit m_tick   = 1'b0;
  bit m_srst   = 1'b0;
  bit m_prev_v = 1'b1;
  bit m_prev_b = 1'b1;
  bit m_bseen  = 1'b0;
  bit m_dseen  = 1'b0;

  game_flow_ctrl #(
    .COUNTDOWN_FRAMES (CD_FRAMES),
    .OVER_FRAMES      (OV_FRAMES),
    .CNT_W            (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vblnk_in        (vblnk_in),
    .btn_start       (btn_start),
    .player_dead     (player_dead),
    .frame_tick      (frame_tick),
    .state_out       (state_out),
    .start_screen_en (start_screen_en),
    .countdown_en    (countdown_en),
    .game_en         (game_en),
    .game_over_en    (game_over_en),
    .score_rst       (score_rst),
    .countdown_val   (countdown_val)
  );

  assign en_obs = {game_over_en, game_en, countdown_en, start_screen_en};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] exp_en();
    return 4'(1 << m_stage);
  endfunction

  function automatic logic [1:0] exp_cd();
    if (m_stage == 1) return 2'(3 - (m_frames * 3) / CD_FRAMES);
    return 2'd3;
  endfunction

  // Advances the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit rise, b, d;
    rise   = btn_start & ~m_prev_b;
    m_srst = 1'b0;
    if (rst) begin
      m_stage = 0; m_frames = 0; m_tick = 1'b0;
      m_prev_v = 1'b1; m_prev_b = 1'b1; m_bseen = 1'b0; m_dseen = 1'b0;
      return;
    end
    if (m_tick) begin
      b = m_bseen | rise;
      d = m_dseen | player_dead;
      case (m_stage)
        0: if (b) begin m_stage = 1; m_frames = 0; m_srst = 1'b1; end
        1: begin
          m_frames++;
          if (m_frames == CD_FRAMES) begin m_stage = 2; m_frames = 0; end
        end
        2: if (d) begin m_stage = 3; m_frames = 0; end
        default: begin
          m_frames++;
          if (m_frames == OV_FRAMES) begin m_stage = 0; m_frames = 0; end
        end
      endcase
      m_bseen = 1'b0;
      m_dseen = 1'b0;
    end else begin
      m_bseen |= rise;
      m_dseen |= player_dead;
    end
    m_tick   = vblnk_in & ~m_prev_v;
    m_prev_v = vblnk_in;
    m_prev_b = btn_start;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_frame();
    vblnk_in = 1'b0;
    repeat (4) cycle();
    vblnk_in = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; vblnk_in = 1'b1; btn_start = 1'b0; player_dead = 1'b0;
    repeat (3) cycle();
    n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_out); end
    n_cmp++; if (en_obs !== 4'b0001) begin n_bad++; $display("FAIL reset_enables: got %b want 0001", en_obs); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    n_cmp++; if (score_rst !== 1'b0) begin n_bad++; $display("FAIL reset_score_rst: got %b want 0", score_rst); end
    n_cmp++; if (countdown_val !== 2'd3) begin n_bad++; $display("FAIL reset_cd_val: got %0d want 3", countdown_val); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL no_spurious_tick: cycle %0d got %b want 0", i, frame_tick); end
    end
    vblnk_in = 1'b0;
    repeat (4) cycle();
    vblnk_in = 1'b1;
    cycle();
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL first_tick: got %b want 1", frame_tick); end
    cycle();
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_width: got %b want 0", frame_tick); end
    n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL idle_start: got %0d want 0", state_out); end
  endtask

  task automatic test_start_press();
    vblnk_in = 1'b0;
    repeat (3) cycle();
    btn_start = 1'b1; cycle();
    btn_start = 1'b0; repeat (3) cycle();
    n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL press_mid_frame: got %0d want 0", state_out); end
    vblnk_in = 1'b1;
    cycle();
    n_cmp++; if (frame_tick !== 1'b1 || state_out !== 2'd0) begin
      n_bad++; $display("FAIL press_tick_cycle: tick %b state %0d want tick 1 state 0", frame_tick, state_out);
    end
    cycle();
    n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL press_to_countdown: got %0d want 1", state_out); end
    n_cmp++; if (en_obs !== 4'b0010) begin n_bad++; $display("FAIL press_enables: got %b want 0010", en_obs); end
    n_cmp++; if (score_rst !== 1'b1) begin n_bad++; $display("FAIL score_rst_pulse: got %b want 1", score_rst); end
    cycle();
    n_cmp++; if (score_rst !== 1'b0) begin n_bad++; $display("FAIL score_rst_width: got %b want 0", score_rst); end
  endtask

  task automatic test_countdown();
    for (int f = 0; f < CD_FRAMES; f++) begin
      vblnk_in = 1'b0;
      repeat (2) cycle();
      btn_start = 1'b1; cycle();
      btn_start = 1'b0; repeat (2) cycle();
      n_cmp++; if (countdown_val !== 2'(3 - f)) begin
        n_bad++; $display("FAIL countdown_val: frame %0d got %0d want %0d", f, countdown_val, 3 - f);
      end
      vblnk_in = 1'b1;
      repeat (2) cycle();
      if (f < CD_FRAMES - 1) begin
        n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL countdown_hold: frame %0d got %0d want 1", f, state_out); end
      end else begin
        n_cmp++; if (state_out !== 2'd2 || game_en !== 1'b1) begin
          n_bad++; $display("FAIL countdown_to_play: state %0d game_en %b want 2/1", state_out, game_en);
        end
      end
    end
  endtask

  task automatic test_play_dead();
    vblnk_in = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    btn_start = 1'b0; repeat (2) cycle();
    vblnk_in = 1'b1; repeat (2) cycle();
    n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL play_ignores_btn: got %0d want 2", state_out); end
    vblnk_in = 1'b0; cycle();
    player_dead = 1'b1; cycle();
    player_dead = 1'b0; repeat (2) cycle();
    n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL dead_mid_frame: got %0d want 2", state_out); end
    vblnk_in = 1'b1; repeat (2) cycle();
    n_cmp++; if (state_out !== 2'd3 || en_obs !== 4'b1000) begin
      n_bad++; $display("FAIL dead_to_over: state %0d en %b want 3/1000", state_out, en_obs);
    end
    run_frame();
    n_cmp++; if (state_out !== 2'd3) begin n_bad++; $display("FAIL over_hold: got %0d want 3", state_out); end
    run_frame();
    n_cmp++; if (state_out !== 2'd0 || en_obs !== 4'b0001) begin
      n_bad++; $display("FAIL over_to_start: state %0d en %b want 0/0001", state_out, en_obs);
    end
  endtask

  task automatic test_same_cycle_btn();
    vblnk_in = 1'b0;
    repeat (4) cycle();
    vblnk_in = 1'b1;
    cycle();
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL same_cycle_tick: got %b want 1", frame_tick); end
    btn_start = 1'b1;
    cycle();
    n_cmp++; if (state_out !== 2'd1 || score_rst !== 1'b1) begin
      n_bad++; $display("FAIL same_cycle_press: state %0d score_rst %b want 1/1", state_out, score_rst);
    end
    btn_start = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_over();
    repeat (CD_FRAMES) run_frame();
    vblnk_in = 1'b0; cycle();
    player_dead = 1'b1; cycle();
    player_dead = 1'b0; repeat (2) cycle();
    vblnk_in = 1'b1; repeat (2) cycle();
    run_frame();
    n_cmp++; if (state_out !== 2'd3 || dut.frame_cnt !== 10'd1) begin
      n_bad++; $display("FAIL over_cnt_one: state %0d cnt %0d want 3/1", state_out, dut.frame_cnt);
    end
    vblnk_in = 1'b0; repeat (2) cycle();
    btn_start = 1'b1; cycle();
    btn_start = 1'b0; cycle();
    rst = 1'b1; cycle();
    n_cmp++; if (state_out !== 2'd0 || en_obs !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid_over: state %0d en %b want 0/0001", state_out, en_obs);
    end
    n_cmp++; if (dut.frame_cnt !== 10'd0) begin n_bad++; $display("FAIL rst_counter: got %0d want 0", dut.frame_cnt); end
    rst = 1'b0; cycle();
    run_frame();
    n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL rst_drops_btn: got %0d want 0", state_out); end
  endtask

  task automatic test_random();
    int act, blk;
    for (int f = 0; f < 120; f++) begin
      act = int'($urandom_range(1, 12));
      blk = int'($urandom_range(1, 5));
      for (int c = 0; c < act + blk; c++) begin
        vblnk_in    = (c >= act);
        btn_start   = ($urandom_range(0, 3) == 0);
        player_dead = ($urandom_range(0, 9) == 0);
        rst         = ($urandom_range(0, 399) == 0);
        cycle();
        n_cmp++; if (state_out !== 2'(m_stage)) begin n_bad++; $display("FAIL rand_state: f%0d c%0d got %0d want %0d", f, c, state_out, m_stage); end
        n_cmp++; if (en_obs !== exp_en()) begin n_bad++; $display("FAIL rand_enables: f%0d c%0d got %b want %b", f, c, en_obs, exp_en()); end
        n_cmp++; if (frame_tick !== m_tick) begin n_bad++; $display("FAIL rand_tick: f%0d c%0d got %b want %b", f, c, frame_tick, m_tick); end
        n_cmp++; if (score_rst !== m_srst) begin n_bad++; $display("FAIL rand_score_rst: f%0d c%0d got %b want %b", f, c, score_rst, m_srst); end
        n_cmp++; if (countdown_val !== exp_cd()) begin n_bad++; $display("FAIL rand_cd_val: f%0d c%0d got %0d want %0d", f, c, countdown_val, exp_cd()); end
      end
    end
    rst = 1'b0; btn_start = 1'b0; player_dead = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vblnk_in = 1'b1; btn_start = 1'b0; player_dead = 1'b0;
    test_reset();
    test_start_press();
    test_countdown();
    test_play_dead();
    test_same_cycle_btn();
    test_reset_mid_over();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
